// File: rtl/alu_ctrl_pkg.sv
// alu_ctrl_pkg
//   Shared encodings for the Execute-stage ALU control decoder: ALUOp
//   classes from the main control unit, the R-type funct codes that are
//   decoded, the 3-bit ALU operation select values, and the register reset
//   value.
package alu_ctrl_pkg;

  // ALUOp classes driven by the main control unit
  localparam logic [1:0] ALUOP_MEM   = 2'b00;  // load/store/addi
  localparam logic [1:0] ALUOP_BR    = 2'b01;  // beq/bne
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;  // decode on funct
  localparam logic [1:0] ALUOP_RSVD  = 2'b11;  // reserved, always illegal

  // R-type funct field values (all six bits are significant)
  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  // ALU operation select. Codes 011/100/101 are never produced.
  typedef enum logic [2:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_ADD = 3'b010,
    ALU_SUB = 3'b110,
    ALU_SLT = 3'b111
  } alu_sel_e;

  // Value loaded into the select register while reset is asserted
  localparam alu_sel_e ALU_CTRL_RST = ALU_ADD;

  // Decoder result bundle
  typedef struct packed {
    alu_sel_e sel;
    logic     illegal;
  } alu_dec_t;

endpackage : alu_ctrl_pkg

// File: rtl/alu_ctrl_if.sv
// alu_ctrl_if
//   Bundles the ALU control request (stall, funct, ALUOp) and the registered
//   response (ALU select, illegal flag).
//   master : the pipeline side driving the request and reading the response
//   slave  : the ALU control unit
interface alu_ctrl_if;
  import alu_ctrl_pkg::*;

  logic       iStall;    // hold the output registers
  logic [5:0] ifunct;    // instruction funct field
  logic [1:0] iALUOp;    // ALU operation class
  logic [2:0] oALUctrl;  // registered ALU operation select
  logic       oIllegal;  // registered undecodable-combination flag

  modport master (
    output iStall,
    output ifunct,
    output iALUOp,
    input  oALUctrl,
    input  oIllegal
  );

  modport slave (
    input  iStall,
    input  ifunct,
    input  iALUOp,
    output oALUctrl,
    output oIllegal
  );
endinterface : alu_ctrl_if

// File: rtl/alu_ctrl_decode.sv
// alu_ctrl_decode
//   Purely combinational ALU control decode, reusable in any pipeline stage.
//   Ports:
//     ifunct   in  6  funct field
//     iALUOp   in  2  ALU operation class
//     oALUsel  out 3  ALU operation select
//     oIllegal out 1  combination is not decodable (select falls back to ADD)
module alu_ctrl_decode
  import alu_ctrl_pkg::*;
(
  input  logic [5:0] ifunct,
  input  logic [1:0] iALUOp,
  output logic [2:0] oALUsel,
  output logic       oIllegal
);

  alu_dec_t dec;

  always_comb begin
    dec.sel     = ALU_ADD;
    dec.illegal = 1'b0;
    case (iALUOp)
      ALUOP_MEM: dec.sel = ALU_ADD;
      ALUOP_BR:  dec.sel = ALU_SUB;
      ALUOP_RTYPE: begin
        // Full 6-bit compare: funct values outside the table are flagged
        // even if their low bits happen to match a legal code.
        case (ifunct)
          FUNCT_ADD: dec.sel = ALU_ADD;
          FUNCT_SUB: dec.sel = ALU_SUB;
          FUNCT_AND: dec.sel = ALU_AND;
          FUNCT_OR:  dec.sel = ALU_OR;
          FUNCT_SLT: dec.sel = ALU_SLT;
          default: begin
            dec.sel     = ALU_ADD;
            dec.illegal = 1'b1;
          end
        endcase
      end
      ALUOP_RSVD: begin
        dec.sel     = ALU_ADD;
        dec.illegal = 1'b1;
      end
      default: begin
        dec.sel     = ALU_ADD;
        dec.illegal = 1'b1;
      end
    endcase
  end

  assign oALUsel  = dec.sel;
  assign oIllegal = dec.illegal;

endmodule : alu_ctrl_decode

// File: rtl/alu_ctrl_unit.sv
// alu_ctrl_unit
//   ALU control for the Execute stage: decodes ALUOp/funct and registers the
//   result so it lines up with the ID/EX boundary.
//   Ports:
//     iClk    in  1  clock, rising edge
//     iReset  in  1  asynchronous active-high reset (select=ADD, illegal=0)
//     bus     slave side of alu_ctrl_if (iStall, ifunct, iALUOp in;
//                                        oALUctrl, oIllegal out)
module alu_ctrl_unit
  import alu_ctrl_pkg::*;
(
  input logic       iClk,
  input logic       iReset,
  alu_ctrl_if.slave bus
);

  logic [2:0] dec_sel;
  logic       dec_illegal;

  logic [2:0] alu_ctrl_q, alu_ctrl_d;
  logic       illegal_q,  illegal_d;

  alu_ctrl_decode u_decode (
    .ifunct   (bus.ifunct),
    .iALUOp   (bus.iALUOp),
    .oALUsel  (dec_sel),
    .oIllegal (dec_illegal)
  );

  // Stall holds the previous result; the current inputs are dropped.
  always_comb begin
    alu_ctrl_d = alu_ctrl_q;
    illegal_d  = illegal_q;
    if (!bus.iStall) begin
      alu_ctrl_d = dec_sel;
      illegal_d  = dec_illegal;
    end
  end

  // Reset takes priority over stall and over any clock edge.
  always_ff @(posedge iClk or posedge iReset) begin
    if (iReset) begin
      alu_ctrl_q <= ALU_CTRL_RST;
      illegal_q  <= 1'b0;
    end else begin
      alu_ctrl_q <= alu_ctrl_d;
      illegal_q  <= illegal_d;
    end
  end

  assign bus.oALUctrl = alu_ctrl_q;
  assign bus.oIllegal = illegal_q;

endmodule : alu_ctrl_unit

// File: tb/tb_alu_ctrl_unit.sv
// tb_alu_ctrl_unit
//   Directed and randomized checks of alu_ctrl_unit against a table-driven
//   reference decode.
module tb_alu_ctrl_unit;

  logic iClk   = 1'b0;
  logic iReset = 1'b0;

  alu_ctrl_if bus ();

  alu_ctrl_unit dut (
    .iClk   (iClk),
    .iReset (iReset),
    .bus    (bus)
  );

  always #5 iClk = ~iClk;

  int vectors     = 0;
  int miscompares = 0;

  logic [2:0] exp_ctrl;
  logic       exp_ill;

  // Reference: the legal R-type mnemonics and the ALU code each one selects
  localparam logic [5:0] RT_FUNCT [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
  localparam logic [2:0] RT_SEL   [5] = '{3'b010,    3'b110,    3'b000,    3'b001,    3'b111};

  function automatic void ref_decode(input logic [1:0] op, input logic [5:0] f,
                                     output logic [2:0] sel, output logic ill);
    sel = 3'b010;
    ill = 1'b0;
    if (op == 2'd0) begin
      sel = 3'b010;
    end else if (op == 2'd1) begin
      sel = 3'b110;
    end else if (op == 2'd3) begin
      ill = 1'b1;
    end else begin
      ill = 1'b1;
      for (int k = 0; k < 5; k++) begin
        if (f == RT_FUNCT[k]) begin
          sel = RT_SEL[k];
          ill = 1'b0;
        end
      end
    end
  endfunction

  task automatic check(input string tag);
    vectors++;
    $display("[%0t] %s: ctrl=%b ill=%b (want %b/%b)", $time, tag,
             bus.oALUctrl, bus.oIllegal, exp_ctrl, exp_ill);
    assert (bus.oALUctrl === exp_ctrl && bus.oIllegal === exp_ill) else begin
      miscompares++;
      $error("FAIL %s: observed ctrl=%b ill=%b expected ctrl=%b ill=%b",
             tag, bus.oALUctrl, bus.oIllegal, exp_ctrl, exp_ill);
    end
  endtask

  // Apply one input set for one edge; outputs are checked 1 time unit later.
  task automatic step(input logic [1:0] op, input logic [5:0] f,
                      input logic stall, input string tag);
    logic [2:0] s;
    logic       i;
    @(negedge iClk);
    bus.iALUOp = op;
    bus.ifunct = f;
    bus.iStall = stall;
    @(posedge iClk);
    #1;
    if (iReset) begin
      exp_ctrl = 3'b010;
      exp_ill  = 1'b0;
    end else if (!stall) begin
      ref_decode(op, f, s, i);
      exp_ctrl = s;
      exp_ill  = i;
    end
    check(tag);
  endtask

  initial begin
    bus.iStall = 1'b0;
    bus.iALUOp = 2'b10;
    bus.ifunct = 6'b101010;

    // Asynchronous reset before any clock edge
    #1 iReset = 1'b1;
    #1;
    exp_ctrl = 3'b010;
    exp_ill  = 1'b0;
    check("reset_async");

    // Edges while reset is held are ignored
    step(2'b10, 6'b101010, 1'b0, "reset_hold_1");
    step(2'b11, 6'b000000, 1'b0, "reset_hold_2");

    @(negedge iClk);
    iReset = 1'b0;

    step(2'b10, 6'b100000, 1'b0, "first_add");

    // R-type sweep
    step(2'b10, 6'b100010, 1'b0, "rt_sub");
    step(2'b10, 6'b100100, 1'b0, "rt_and");
    step(2'b10, 6'b100101, 1'b0, "rt_or");
    step(2'b10, 6'b101010, 1'b0, "rt_slt");

    // Non-R classes ignore funct
    step(2'b00, 6'b101010, 1'b0, "mem_add");
    step(2'b01, 6'b100100, 1'b0, "br_sub");

    // Illegal combinations
    step(2'b10, 6'b000000, 1'b0, "rt_illegal");
    step(2'b11, 6'b100010, 1'b0, "rsvd_illegal");
    step(2'b10, 6'b001010, 1'b0, "rt_hibits_illegal");

    // Stall holds SUB for three edges, then OR loads
    step(2'b01, 6'b100000, 1'b0, "stall_load");
    step(2'b10, 6'b100101, 1'b1, "stall_1");
    step(2'b10, 6'b100101, 1'b1, "stall_2");
    step(2'b10, 6'b100101, 1'b1, "stall_3");
    step(2'b10, 6'b100101, 1'b0, "stall_release");

    // Stall also holds an illegal flag
    step(2'b11, 6'b000000, 1'b0, "stall_ill_load");
    step(2'b00, 6'b000000, 1'b1, "stall_ill_hold");

    // Async reset mid-run, then reset together with stall
    step(2'b10, 6'b101010, 1'b0, "mid_slt");
    @(negedge iClk);
    #1 iReset = 1'b1;
    #1;
    exp_ctrl = 3'b010;
    exp_ill  = 1'b0;
    check("mid_reset_async");
    step(2'b10, 6'b101010, 1'b1, "reset_with_stall");
    @(negedge iClk);
    iReset = 1'b0;
    step(2'b10, 6'b100100, 1'b0, "post_reset_and");

    // Randomized run
    for (int n = 0; n < 200; n++) begin
      logic [1:0] op;
      logic [5:0] f;
      logic       st;
      op = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1)
        f = RT_FUNCT[$urandom_range(0, 4)];
      else
        f = 6'($urandom);
      st = ($urandom_range(0, 7) == 0);
      step(op, f, st, "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_alu_ctrl_unit
